// File: rtl/gray_counter_n.sv
// ---------------------------------------------------------------------------
// gray_counter_n
//   Up/down binary counter with a registered Gray-coded copy of the count.
//   It can be loaded from a Gray-coded value, and at the ends of the range it
//   either wraps around (WRAP_MODE=1) or saturates (WRAP_MODE=0).
//   Every output comes straight from a flop, so no input reaches an output
//   combinationally.
//
// Parameters
//   WIDTH      counter width in bits, 2..16
//   WRAP_MODE  1 = wrap modulo 2^WIDTH, 0 = saturate at 0 / all-ones
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears every output
//   en         count enable
//   up         direction: 1 = increment, 0 = decrement
//   load       synchronous load strobe; has priority over en
//   load_gray  Gray-coded value taken on load
//   bin_out    registered binary count
//   gray_out   registered Gray code of bin_out
//   wrap       one-cycle pulse on the edge that wrapped (WRAP_MODE=1 only)
//   sat        level, high while a count is blocked at an end (WRAP_MODE=0 only)
// ---------------------------------------------------------------------------
module gray_counter_n #(
    parameter int WIDTH     = 4,
    parameter int WRAP_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             sat
);

    localparam bit               WRAPS    = (WRAP_MODE != 0);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic             at_end;     // current count sits at the end we are moving toward
    logic [WIDTH-1:0] step_val;   // count after one step in the current direction
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    always_comb begin
        at_end   = up ? (bin_out == ALL_ONES) : (bin_out == '0);
        step_val = up ? (bin_out + ONE) : (bin_out - ONE);
    end

    // Priority: load, then en, then hold. wrap is a pulse, so it defaults low;
    // sat is a level, so it defaults to its current value.
    always_comb begin
        bin_nxt  = bin_out;
        wrap_nxt = 1'b0;
        sat_nxt  = sat;
        if (load) begin
            bin_nxt = gray2bin(load_gray);
            sat_nxt = 1'b0;
        end else if (en) begin
            if (at_end && !WRAPS) begin
                // blocked at the end: count holds, flag it
                sat_nxt = 1'b1;
            end else begin
                // modulo arithmetic on WIDTH bits gives the wrap for free;
                // at_end can only be true here in wrapping mode
                bin_nxt  = step_val;
                wrap_nxt = at_end;
                sat_nxt  = 1'b0;
            end
        end
        if (WRAPS) begin
            sat_nxt = 1'b0;
        end
    end

    // Gray is encoded from the next binary value and registered on the same
    // edge, so the two outputs can never disagree for a cycle.
    assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out  <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
            sat      <= 1'b0;
        end else begin
            bin_out  <= bin_nxt;
            gray_out <= gray_nxt;
            wrap     <= wrap_nxt;
            sat      <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_gray_counter_n.sv
// ---------------------------------------------------------------------------
// tb_gray_counter_n
//   Three counters side by side: 3-bit wrapping, 3-bit saturating and 8-bit
//   wrapping. An integer-arithmetic model predicts every output and one
//   process compares all of them on each falling edge; directed steps add
//   literal expectations.
// ---------------------------------------------------------------------------
module tb_gray_counter_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en_v [3];
    logic        up_v [3];
    logic        ld_v [3];
    logic [15:0] lg_v [3];

    logic [2:0] bin0, gray0, bin1, gray1;
    logic [7:0] bin2, gray2;
    logic       wrap0, sat0, wrap1, sat1, wrap2, sat2;

    gray_counter_n #(.WIDTH(3), .WRAP_MODE(1)) u_w3 (
        .clk(clk), .rst(rst), .en(en_v[0]), .up(up_v[0]), .load(ld_v[0]),
        .load_gray(lg_v[0][2:0]), .bin_out(bin0), .gray_out(gray0),
        .wrap(wrap0), .sat(sat0));

    gray_counter_n #(.WIDTH(3), .WRAP_MODE(0)) u_s3 (
        .clk(clk), .rst(rst), .en(en_v[1]), .up(up_v[1]), .load(ld_v[1]),
        .load_gray(lg_v[1][2:0]), .bin_out(bin1), .gray_out(gray1),
        .wrap(wrap1), .sat(sat1));

    gray_counter_n #(.WIDTH(8), .WRAP_MODE(1)) u_w8 (
        .clk(clk), .rst(rst), .en(en_v[2]), .up(up_v[2]), .load(ld_v[2]),
        .load_gray(lg_v[2][7:0]), .bin_out(bin2), .gray_out(gray2),
        .wrap(wrap2), .sat(sat2));

    logic [15:0] act_bin [3];
    logic [15:0] act_gray[3];
    logic [15:0] act_wrap[3];
    logic [15:0] act_sat [3];

    always_comb begin
        act_bin[0]  = 16'(bin0);  act_gray[0] = 16'(gray0);
        act_bin[1]  = 16'(bin1);  act_gray[1] = 16'(gray1);
        act_bin[2]  = 16'(bin2);  act_gray[2] = 16'(gray2);
        act_wrap[0] = 16'(wrap0); act_sat[0]  = 16'(sat0);
        act_wrap[1] = 16'(wrap1); act_sat[1]  = 16'(sat1);
        act_wrap[2] = 16'(wrap2); act_sat[2]  = 16'(sat2);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int bin;
        bit wrap;
        bit sat;
        bit step;   // the last edge was a counted step
    } mstate_t;

    function automatic int width_of(input int k);
        return (k == 2) ? 8 : 3;
    endfunction

    function automatic bit wraps_of(input int k);
        return (k != 1);
    endfunction

    // Decode by search: the binary value whose Gray encoding equals g.
    function automatic int gray_decode(input int w, input int g);
        int top = (1 << w) - 1;
        int r   = 0;
        for (int b = 0; b <= top; b++) begin
            if (((b ^ (b >> 1)) & top) == (g & top)) r = b;
        end
        return r;
    endfunction

    function automatic mstate_t model_next(input int k, input mstate_t cur,
                                           input bit en, input bit up,
                                           input bit ld, input int g);
        mstate_t n;
        int top = (1 << width_of(k)) - 1;
        n      = cur;
        n.wrap = 1'b0;
        n.step = 1'b0;
        if (ld) begin
            n.bin = gray_decode(width_of(k), g);
            n.sat = 1'b0;
        end else if (en) begin
            if (up && cur.bin == top) begin
                if (wraps_of(k)) begin n.bin = 0; n.wrap = 1'b1; n.step = 1'b1; end
                else n.sat = 1'b1;
            end else if (!up && cur.bin == 0) begin
                if (wraps_of(k)) begin n.bin = top; n.wrap = 1'b1; n.step = 1'b1; end
                else n.sat = 1'b1;
            end else begin
                n.bin  = up ? cur.bin + 1 : cur.bin - 1;
                n.sat  = 1'b0;
                n.step = 1'b1;
            end
        end
        return n;
    endfunction

    mstate_t m [3];

    initial begin
        for (int k = 0; k < 3; k++) m[k] = '{0, 1'b0, 1'b0, 1'b0};
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) m[k] <= '{0, 1'b0, 1'b0, 1'b0};
        end else begin
            for (int k = 0; k < 3; k++)
                m[k] <= model_next(k, m[k], en_v[k], up_v[k], ld_v[k], int'(lg_v[k]));
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        chk_on = 1'b0;
    logic [15:0] prev_gray [3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (chk_on) begin
                chk("bin", k, act_bin[k], 16'(m[k].bin));
                chk("gray", k, act_gray[k], 16'(m[k].bin ^ (m[k].bin >> 1)));
                chk("gray_of_bin", k, act_gray[k], act_bin[k] ^ (act_bin[k] >> 1));
                chk("wrap", k, act_wrap[k], 16'(m[k].wrap));
                chk("sat", k, act_sat[k], 16'(m[k].sat));
                if (m[k].step)
                    chk("gray_one_bit", k, 16'($countones(act_gray[k] ^ prev_gray[k])), 16'd1);
            end
            prev_gray[k] = act_gray[k];
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] up_tbl [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                               3'b101, 3'b100, 3'b000, 3'b001};

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en_v[k] = 1'b0; up_v[k] = 1'b1; ld_v[k] = 1'b0; lg_v[k] = '0;
        end
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("rst_bin", k, act_bin[k], 16'd0);
            chk("rst_gray", k, act_gray[k], 16'd0);
            chk("rst_wrap", k, act_wrap[k], 16'd0);
            chk("rst_sat", k, act_sat[k], 16'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;

        // Up count on the 3-bit wrapper; first edges after reset on all three.
        for (int k = 0; k < 3; k++) en_v[k] = 1'b1;
        up_v[0] = 1'b1; up_v[1] = 1'b1; up_v[2] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            en_v[1] = (i < 7);
            if (i == 1) en_v[2] = 1'b0;
            step();
            chk("up_seq_gray", 0, act_gray[0], 16'(up_tbl[i]));
            chk("up_seq_wrap", 0, act_wrap[0], 16'(i == 7));
            if (i == 0) begin
                chk("first_up", 0, act_bin[0], 16'd1);
                chk("first_up", 1, act_bin[1], 16'd1);
                chk("first_down", 2, act_bin[2], 16'd255);
                chk("first_down_wrap", 2, act_wrap[2], 16'd1);
            end
        end
        en_v[0] = 1'b0;
        chk("sat_top_reached", 1, act_bin[1], 16'd7);

        // Saturation on the 3-bit saturating counter.
        en_v[1] = 1'b1; up_v[1] = 1'b1;
        repeat (3) begin
            step();
            chk("sat_hold_bin", 1, act_bin[1], 16'd7);
            chk("sat_level", 1, act_sat[1], 16'd1);
            chk("sat_no_wrap", 1, act_wrap[1], 16'd0);
        end
        en_v[1] = 1'b0;
        step();
        chk("sat_idle_keeps", 1, act_sat[1], 16'd1);
        ld_v[1] = 1'b1; lg_v[1] = 16'b100; en_v[1] = 1'b1;
        step();
        chk("load_clears_sat", 1, act_sat[1], 16'd0);
        chk("load_bin", 1, act_bin[1], 16'd7);
        ld_v[1] = 1'b0;
        step();
        chk("sat_again", 1, act_sat[1], 16'd1);
        up_v[1] = 1'b0;
        step();
        chk("sat_release_bin", 1, act_bin[1], 16'd6);
        chk("sat_release_flag", 1, act_sat[1], 16'd0);
        en_v[1] = 1'b0;

        // Down wrap from zero.
        ld_v[0] = 1'b1; lg_v[0] = 16'b000; en_v[0] = 1'b1; up_v[0] = 1'b1;
        step();
        chk("load_zero", 0, act_bin[0], 16'd0);
        ld_v[0] = 1'b0; up_v[0] = 1'b0;
        step();
        chk("down_wrap_bin", 0, act_bin[0], 16'd7);
        chk("down_wrap_gray", 0, act_gray[0], 16'b100);
        chk("down_wrap_pulse", 0, act_wrap[0], 16'd1);
        step();
        chk("down_next_bin", 0, act_bin[0], 16'd6);
        chk("down_next_gray", 0, act_gray[0], 16'b101);
        chk("wrap_one_cycle", 0, act_wrap[0], 16'd0);
        en_v[0] = 1'b0;
        step();
        chk("hold_bin", 0, act_bin[0], 16'd6);

        // Load beats en; Gray 110 decodes to binary 100.
        ld_v[0] = 1'b1; lg_v[0] = 16'b110; en_v[0] = 1'b1; up_v[0] = 1'b0;
        step();
        chk("load_pri_bin", 0, act_bin[0], 16'b100);
        chk("load_pri_gray", 0, act_gray[0], 16'b110);
        lg_v[0] = 16'b111; en_v[0] = 1'b0;
        step();
        chk("load_bin5", 0, act_bin[0], 16'd5);
        ld_v[0] = 1'b0;

        // Asynchronous reset between edges, with a coincident load.
        #2;
        rst = 1'b1; ld_v[0] = 1'b1; lg_v[0] = 16'b010; en_v[0] = 1'b1;
        #1;
        chk("async_bin", 0, act_bin[0], 16'd0);
        chk("async_gray", 0, act_gray[0], 16'd0);
        chk("async_bin", 2, act_bin[2], 16'd0);
        step();
        chk("rst_beats_load", 0, act_bin[0], 16'd0);
        rst = 1'b0; ld_v[0] = 1'b0; en_v[0] = 1'b0;
        step();
        chk("post_rst_idle", 0, act_bin[0], 16'd0);
        en_v[0] = 1'b1; up_v[0] = 1'b1;
        step();
        chk("post_rst_up", 0, act_bin[0], 16'd1);

        // Random en/up traffic; occasional loads on the 3-bit counters only.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 3; k++) begin
                en_v[k] = ($urandom_range(0, 3) != 0);
                up_v[k] = $urandom_range(0, 1);
                ld_v[k] = (k != 2) && ($urandom_range(0, 15) == 0);
                lg_v[k] = 16'($urandom_range(0, 7));
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            en_v[k] = 1'b0; ld_v[k] = 1'b0;
        end
        step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter_n.md
GRAY_COUNTER_N -- requirements
Module: gray_counter_n

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-002 Parameter WRAP_MODE, default 1: 1 = wrap at the ends of the range, 0 = saturate at the ends.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port up, input, 1: direction; 1 = increment, 0 = decrement.
REQ-007 Port load, input, 1: synchronous load strobe.
REQ-008 Port load_gray, input, WIDTH: Gray-coded value to load.
REQ-009 Port bin_out, output, WIDTH: registered binary count.
REQ-010 Port gray_out, output, WIDTH: registered Gray code of bin_out.
REQ-011 Port wrap, output, 1: registered one-cycle pulse on wrap-around.
REQ-012 Port sat, output, 1: registered level, high while a count is blocked at a range end (WRAP_MODE=0 only).

Function
REQ-013 All outputs shall be registered; no combinational path shall exist from any input to any output.
REQ-014 gray_out shall equal bin_out ^ (bin_out >> 1) in every cycle, with both updated on the same edge.
REQ-015 Priority each edge shall be: load, then en, then hold.
REQ-016 On load=1, bin_out shall take the binary decode of load_gray (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]), ignoring en and up; wrap=0 and sat=0 on the next cycle.
REQ-017 On en=1 and load=0, bin_out shall step by +1 (up=1) or -1 (up=0), modulo 2^WIDTH when WRAP_MODE=1.
REQ-018 On en=0 and load=0, bin_out and gray_out shall hold, wrap shall be 0, and sat shall hold its value.
REQ-019 WRAP_MODE=1, up=1 at all-ones: next bin_out=0 and wrap=1 for exactly one cycle.
REQ-020 WRAP_MODE=1, up=0 at zero: next bin_out=all-ones and wrap=1 for exactly one cycle.
REQ-021 WRAP_MODE=1: sat shall be constant 0.
REQ-022 WRAP_MODE=0, en=1 at the end in the count direction (all-ones up, zero down): bin_out shall hold and sat=1.
REQ-023 WRAP_MODE=0: any successful step or load shall clear sat; wrap shall be constant 0.
REQ-024 Consecutive counted steps shall change exactly one bit of gray_out; load may change several bits.
REQ-025 Latency shall be one clock from a sampled en/load to the updated outputs.
REQ-026 Changing up between cycles shall take effect on the next enabled edge, with no extra step and no skip.

Reset
REQ-027 While rst=1, bin_out=0, gray_out=0, wrap=0 and sat=0, immediately and independently of clk.
REQ-028 Reset asserted mid-count or coincident with load shall win; the load shall be discarded.
REQ-029 After rst falls, the first rising edge with en=1 shall produce bin_out=1 (up=1) or, in WRAP_MODE=1, all-ones (up=0).

Verification (WIDTH=3 unless noted)
REQ-030 Up count: rst pulse, then en=1, up=1 for 9 clocks -> gray_out 001,011,010,110,111,101,100,000,001; wrap=1 only on the 100->000 cycle.
REQ-031 Down wrap: from bin 0, en=1, up=0 -> bin 7, gray 100, wrap pulse of 1 cycle; next edge -> bin 6, gray 101.
REQ-032 Load: load=1, load_gray=110 with en=1 in the same cycle -> bin_out=100, gray_out=110 next cycle, no count step.
REQ-033 Saturate (WRAP_MODE=0): count up to 7, hold en=1 for 3 more clocks -> bin stays 7, sat=1, wrap=0; then up=0 -> bin 6, sat=0.
REQ-034 Async reset: assert rst between clock edges at bin=5 -> outputs go to 0 before the next edge; load coincident with rst is ignored.
REQ-035 Property check (WIDTH=8): 600 random en/up cycles with no load -> every counted step changes one gray_out bit, and the gray_out==bin^(bin>>1) check passes every cycle.
